// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scan-code decoder: make/break/extended tracking, ASCII, press count, 7-seg display
//
// Ports:
//   clk          system clock
//   resetn       asynchronous reset, active-high
//   code_valid   one-cycle strobe, code_data holds a checked scan-code byte
//   code_data    received scan-code byte
//   key_pressed  a key is currently held
//   key_ext      held key was E0-prefixed
//   cur_code     scan code of held/last key
//   cur_ascii    ASCII of cur_code, 0x00 if unmapped or extended
//   press_count  number of distinct presses, wraps
//   hex0..hex5   active-low segments {dp,g,f,e,d,c,b,a}
module ps2_key_decoder #(
   parameter int TIMEOUT_CYC = 2000000,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             code_valid,
   input  logic [7:0]       code_data,
   output logic             key_pressed,
   output logic             key_ext,
   output logic [7:0]       cur_code,
   output logic [7:0]       cur_ascii,
   output logic [CNT_W-1:0] press_count,
   output logic [7:0]       hex0,
   output logic [7:0]       hex1,
   output logic [7:0]       hex2,
   output logic [7:0]       hex3,
   output logic [7:0]       hex4,
   output logic [7:0]       hex5
);

   localparam int            TW      = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [TW-1:0]      to_cnt, to_cnt_nxt;
   logic               kp_nxt, ext_nxt;
   logic [7:0]         code_nxt, ascii_nxt;
   logic [CNT_W-1:0]   cnt_nxt;

   function automatic logic [7:0] ascii_of(input logic [7:0] sc);
      case (sc)
         8'h1C: ascii_of = 8'h61;  8'h32: ascii_of = 8'h62;
         8'h21: ascii_of = 8'h63;  8'h23: ascii_of = 8'h64;
         8'h24: ascii_of = 8'h65;  8'h2B: ascii_of = 8'h66;
         8'h34: ascii_of = 8'h67;  8'h33: ascii_of = 8'h68;
         8'h43: ascii_of = 8'h69;  8'h3B: ascii_of = 8'h6A;
         8'h42: ascii_of = 8'h6B;  8'h4B: ascii_of = 8'h6C;
         8'h3A: ascii_of = 8'h6D;  8'h31: ascii_of = 8'h6E;
         8'h44: ascii_of = 8'h6F;  8'h4D: ascii_of = 8'h70;
         8'h15: ascii_of = 8'h71;  8'h2D: ascii_of = 8'h72;
         8'h1B: ascii_of = 8'h73;  8'h2C: ascii_of = 8'h74;
         8'h3C: ascii_of = 8'h75;  8'h2A: ascii_of = 8'h76;
         8'h1D: ascii_of = 8'h77;  8'h22: ascii_of = 8'h78;
         8'h35: ascii_of = 8'h79;  8'h1A: ascii_of = 8'h7A;
         8'h45: ascii_of = 8'h30;  8'h16: ascii_of = 8'h31;
         8'h1E: ascii_of = 8'h32;  8'h26: ascii_of = 8'h33;
         8'h25: ascii_of = 8'h34;  8'h2E: ascii_of = 8'h35;
         8'h36: ascii_of = 8'h36;  8'h3D: ascii_of = 8'h37;
         8'h3E: ascii_of = 8'h38;  8'h46: ascii_of = 8'h39;
         8'h29: ascii_of = 8'h20;  8'h5A: ascii_of = 8'h0D;
         default: ascii_of = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;
         4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
         4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;
         4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
         4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;
         4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
         4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;
         4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
      endcase
   endfunction

   // A make is a new press unless it repeats the key already held
   // (same code, same extended flag): that is keyboard typematic.
   logic new_plain, new_ext;
   assign new_plain = !key_pressed || (code_data != cur_code) ||  key_ext;
   assign new_ext   = !key_pressed || (code_data != cur_code) || !key_ext;

   always_comb begin
      state_nxt  = state;
      to_cnt_nxt = to_cnt;
      kp_nxt     = key_pressed;
      ext_nxt    = key_ext;
      code_nxt   = cur_code;
      ascii_nxt  = cur_ascii;
      cnt_nxt    = press_count;
      if (code_valid) begin
         // A byte always wins over a timeout landing on the same edge.
         to_cnt_nxt = '0;
         case (state)
            IDLE: begin
               if (code_data == 8'hE0)      state_nxt = EXT;
               else if (code_data == 8'hF0) state_nxt = BRK;
               else if (new_plain) begin
                  code_nxt  = code_data;
                  ext_nxt   = 1'b0;
                  ascii_nxt = ascii_of(code_data);
                  kp_nxt    = 1'b1;
                  cnt_nxt   = press_count + 1'b1;
               end
            end
            EXT: begin
               if (code_data == 8'hF0)      state_nxt = EXT_BRK;
               else if (code_data == 8'hE0) state_nxt = EXT;
               else begin
                  state_nxt = IDLE;
                  if (new_ext) begin
                     code_nxt  = code_data;
                     ext_nxt   = 1'b1;
                     ascii_nxt = 8'h00;
                     kp_nxt    = 1'b1;
                     cnt_nxt   = press_count + 1'b1;
                  end
               end
            end
            BRK: begin
               state_nxt = IDLE;
               if (key_pressed && !key_ext && code_data == cur_code)
                  kp_nxt = 1'b0;
            end
            default: begin
               state_nxt = IDLE;
               if (key_pressed && key_ext && code_data == cur_code)
                  kp_nxt = 1'b0;
            end
         endcase
      end else if (state != IDLE) begin
         // Abandon a prefix whose follow-up byte never came.
         if (to_cnt == TO_LAST) begin
            state_nxt  = IDLE;
            to_cnt_nxt = '0;
         end else begin
            to_cnt_nxt = to_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state       <= IDLE;
         to_cnt      <= '0;
         key_pressed <= 1'b0;
         key_ext     <= 1'b0;
         cur_code    <= 8'h00;
         cur_ascii   <= 8'h00;
         press_count <= '0;
      end else begin
         state       <= state_nxt;
         to_cnt      <= to_cnt_nxt;
         key_pressed <= kp_nxt;
         key_ext     <= ext_nxt;
         cur_code    <= code_nxt;
         cur_ascii   <= ascii_nxt;
         press_count <= cnt_nxt;
      end
   end

   // Display is registered from the status registers, so it trails them by one edge.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         hex0 <= 8'hFF;
         hex1 <= 8'hFF;
         hex2 <= 8'hFF;
         hex3 <= 8'hFF;
         hex4 <= 8'hC0;
         hex5 <= 8'hC0;
      end else begin
         hex0 <= key_pressed ? seg7(cur_code[3:0])  : 8'hFF;
         hex1 <= key_pressed ? seg7(cur_code[7:4])  : 8'hFF;
         hex2 <= key_pressed ? seg7(cur_ascii[3:0]) : 8'hFF;
         hex3 <= key_pressed ? seg7(cur_ascii[7:4]) : 8'hFF;
         hex4 <= seg7(press_count[3:0]);
         hex5 <= seg7(press_count[7:4]);
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       code_valid = 1'b0;
   logic [7:0] code_data = 8'h00;
   logic       key_pressed, key_ext;
   logic [7:0] cur_code, cur_ascii, press_count;
   logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;

   int total = 0;
   int passed = 0;

   ps2_key_decoder #(.TIMEOUT_CYC(T), .CNT_W(8)) dut (
      .clk(clk), .resetn(resetn),
      .code_valid(code_valid), .code_data(code_data),
      .key_pressed(key_pressed), .key_ext(key_ext),
      .cur_code(cur_code), .cur_ascii(cur_ascii), .press_count(press_count),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
   endtask

   // Returns two edges after the byte was sampled, so the display has settled.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      code_valid = 1'b1;
      code_data  = b;
      @(negedge clk);
      code_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic chk_state(input string tag, input logic kp, input logic ext,
                            input logic [7:0] code, input logic [7:0] asc, input logic [7:0] cnt);
      chk({tag, ".key_pressed"}, 8'(key_pressed), 8'(kp));
      chk({tag, ".key_ext"},     8'(key_ext),     8'(ext));
      chk({tag, ".cur_code"},    cur_code,        code);
      chk({tag, ".cur_ascii"},   cur_ascii,       asc);
      chk({tag, ".press_count"}, press_count,     cnt);
   endtask

   task automatic chk_disp(input string tag, input logic [7:0] e5, input logic [7:0] e4,
                           input logic [7:0] e3, input logic [7:0] e2,
                           input logic [7:0] e1, input logic [7:0] e0);
      chk({tag, ".hex5"}, hex5, e5);
      chk({tag, ".hex4"}, hex4, e4);
      chk({tag, ".hex3"}, hex3, e3);
      chk({tag, ".hex2"}, hex2, e2);
      chk({tag, ".hex1"}, hex1, e1);
      chk({tag, ".hex0"}, hex0, e0);
   endtask

   initial begin
      idle(3);
      resetn = 1'b0;
      idle(2);
      chk_state("reset", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      chk_disp("reset", 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

      // First make and its display one edge later.
      send(8'h1C);
      chk_state("make_a", 1'b1, 1'b0, 8'h1C, 8'h61, 8'h01);
      chk_disp("make_a", 8'hC0, 8'hF9, 8'h82, 8'hF9, 8'hF9, 8'hC6);
      send(8'hF0); send(8'h1C);
      chk_state("brk_a", 1'b0, 1'b0, 8'h1C, 8'h61, 8'h01);
      chk_disp("brk_a", 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

      // Typematic repeats count once.
      send(8'h1C); send(8'h1C); send(8'h1C);
      chk("typematic.count", press_count, 8'h02);
      send(8'hF0); send(8'h1C);
      send(8'h32);
      chk_state("make_b", 1'b1, 1'b0, 8'h32, 8'h62, 8'h03);
      chk_disp("make_b", 8'hC0, 8'hB0, 8'h82, 8'hA4, 8'hB0, 8'hA4);
      send(8'hF0); send(8'h32);

      // Digit, space and unmapped lookups.
      send(8'h45);
      chk_state("make_0", 1'b1, 1'b0, 8'h45, 8'h30, 8'h04);
      send(8'hF0); send(8'h45);
      send(8'h29);
      chk("space.ascii", cur_ascii, 8'h20);
      send(8'hF0); send(8'h29);
      send(8'h5A);
      chk("enter.ascii", cur_ascii, 8'h0D);
      send(8'hF0); send(8'h5A);
      send(8'h76);
      chk_state("unmapped", 1'b1, 1'b0, 8'h76, 8'h00, 8'h07);
      send(8'hF0); send(8'h76);

      // Extended key; plain break of the same code must not release it.
      send(8'hE0); send(8'h75);
      chk_state("ext_make", 1'b1, 1'b1, 8'h75, 8'h00, 8'h08);
      chk_disp("ext_make", 8'hC0, 8'h80, 8'hC0, 8'hC0, 8'hF8, 8'h92);
      send(8'hE0); send(8'h75);
      chk("ext_typematic.count", press_count, 8'h08);
      send(8'hF0); send(8'h75);
      chk("plain_brk_ignored", 8'(key_pressed), 8'h01);
      send(8'hE0); send(8'hF0); send(8'h75);
      chk_state("ext_brk", 1'b0, 1'b1, 8'h75, 8'h00, 8'h08);

      // Timeout: E0 abandoned, 1C is a plain make.
      send(8'hE0);
      idle(T - 2);
      send(8'h1C);
      chk_state("timeout", 1'b1, 1'b0, 8'h1C, 8'h61, 8'h09);
      send(8'hF0); send(8'h1C);

      // Byte arriving on the timeout edge is still taken as extended.
      send(8'hE0);
      idle(T - 3);
      send(8'h75);
      chk_state("byte_wins", 1'b1, 1'b1, 8'h75, 8'h00, 8'h0A);
      send(8'hE0); send(8'hF0); send(8'h75);

      // Counter wrap: 245 more presses reach 255, one more wraps to 0.
      for (int i = 0; i < 245; i++) begin
         send((i % 2 == 0) ? 8'h1C : 8'h32);
         send(8'hF0);
         send((i % 2 == 0) ? 8'h1C : 8'h32);
      end
      chk("count_255", press_count, 8'hFF);
      chk("count_255.hex5", hex5, 8'h8E);
      chk("count_255.hex4", hex4, 8'h8E);
      send(8'h32); send(8'hF0); send(8'h32);
      chk("count_wrap", press_count, 8'h00);
      chk("count_wrap.hex5", hex5, 8'hC0);
      chk("count_wrap.hex4", hex4, 8'hC0);

      // Reset after F0: asynchronous clear, next byte seen from IDLE.
      send(8'h1C);
      send(8'hF0);
      #2;
      resetn = 1'b1;
      #1;
      chk("async_reset.count", press_count, 8'h00);
      chk("async_reset.kp", 8'(key_pressed), 8'h00);
      @(negedge clk);
      resetn = 1'b0;
      send(8'h1C);
      chk_state("after_reset", 1'b1, 1'b0, 8'h1C, 8'h61, 8'h01);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Downstream consumer of the PS/2 frame receiver. Takes validated scan-code bytes and tracks make/break (F0) and extended (E0) prefixes.
- Holds the currently pressed key, translates it to ASCII and counts distinct key presses.
- Drives six active-low seven-segment digits: scan code, ASCII and press count.

Parameters:
TIMEOUT_CYC, 2000000, clk cycles a prefix state may wait for its next byte before abandoning the sequence (min 2).
CNT_W, 8, press counter width; fixed at 8 for display purposes.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous reset, active-high
code_valid  input  1  one-cycle strobe: code_data holds a parity/framing-checked byte
code_data  input  8  received scan-code byte
key_pressed  output  1  a key is currently held
key_ext  output  1  held key was E0-prefixed
cur_code  output  8  scan code of held/last key
cur_ascii  output  8  ASCII of cur_code; 0x00 if unmapped or extended
press_count  output  8  number of distinct presses, wraps 255->0
hex0..hex5  output  8 each  segments {dp,g,f,e,d,c,b,a}, active-low, dp always 1

Behaviour:
- Clock and reset: reset resetn, asynchronous, active-high; clock clk.
- Reset values:
  - FSM = IDLE; timeout counter 0.
  - key_pressed, key_ext, cur_code, cur_ascii, press_count all 0.
  - hex0-hex3 = 0xFF (blank); hex4 = hex5 = 0xC0 ("00").
- A byte is consumed only on a clk edge with code_valid=1. code_valid is never asserted on consecutive cycles.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE:
  - 0xE0 -> EXT.
  - 0xF0 -> BRK.
  - Any other byte is a make code:
    - New press if key_pressed=0, or if (byte, ext=0) differs from (cur_code, key_ext): cur_code<=byte, key_ext<=0, cur_ascii<=lookup(byte), key_pressed<=1, press_count+1.
    - Otherwise it is a typematic repeat: no change.
- EXT:
  - 0xF0 -> EXT_BRK.
  - 0xE0 -> stay.
  - Other byte: same make rule with ext=1; cur_ascii<=0x00. Then -> IDLE.
- BRK: byte equal to cur_code with key_ext=0 and key_pressed=1 -> key_pressed<=0. Any byte -> IDLE. Non-matching break is ignored.
- EXT_BRK: same as BRK with key_ext=1 required -> IDLE.
- Release keeps cur_code, cur_ascii and key_ext; only key_pressed clears.
- Timeout:
  - The counter clears on every consumed byte and counts while in EXT, BRK or EXT_BRK.
  - On reaching TIMEOUT_CYC-1 the FSM -> IDLE, with no other state change.
  - A byte arriving in the same cycle as the timeout is processed as in the prefix state; the byte wins.
- ASCII lookup (lowercase); all other codes -> 0x00:
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Others: 29 -> 0x20, 5A -> 0x0D.
- Display:
  - Digit mapping: hex1:hex0 = cur_code, hex3:hex2 = cur_ascii, hex5:hex4 = press_count (high:low nibble).
  - hex0-hex3 read 0xFF while key_pressed=0. hex4/hex5 always show the count.
  - Nibble encoding: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Latency:
  - State and status outputs update on the edge consuming the byte.
  - hex outputs are registered from those and update one edge later (2 edges after the code_valid sample).
- Reset mid-sequence, e.g. after E0: everything returns to reset values immediately. The next byte is interpreted from IDLE.

Test Plan:
- Reset, then bytes 1C, F0, 1C -> after 1C: key_pressed=1, cur_ascii=0x61, press_count=1, hex1/hex0=F9/C6, hex3/hex2=82/F9, hex4=F9. After F0 1C: key_pressed=0, hex0-3=FF, press_count stays 1.
- 1C, 1C, 1C (typematic), F0, 1C, then 32 -> press_count=2 (not 4); cur_code=0x32, cur_ascii=0x62.
- E0, 75 then E0, F0, 75 -> key_ext=1, cur_ascii=0x00, press_count+1; release clears key_pressed. A plain F0, 75 while the E0-75 key is held is ignored.
- E0, then no byte for TIMEOUT_CYC cycles, then 1C -> FSM back in IDLE; 1C treated as a non-extended make, key_ext=0.
- 256 distinct make/break pairs alternating 1C and 32 -> press_count wraps to 0x00, hex5/hex4=C0/C0.
- Send F0, assert resetn for 1 cycle, then send 1C -> make recognised: key_pressed=1, press_count=1.
